// File: rtl/pixel_stream_feeder_pkg.sv
// Shared types and constants for the pixel stream feeder: pixel width, default frame
// geometry and FSM state encoding.
package pixel_stream_feeder_pkg;

   localparam int unsigned RGB_W            = 24;
   localparam int unsigned ENTRY_W          = RGB_W + 1;
   localparam int unsigned DEF_FIFO_DEPTH   = 16;
   localparam int unsigned DEF_FRAME_WIDTH  = 640;
   localparam int unsigned DEF_FRAME_HEIGHT = 480;

   typedef enum logic [1:0] {
      FEED_IDLE     = 2'd0,
      FEED_WAIT_ACK = 2'd1,
      FEED_WAIT_RDY = 2'd2
   } feed_state_e;

   typedef struct packed {
      logic             sof;
      logic [RGB_W-1:0] rgb;
   } feed_entry_t;

endpackage

// File: rtl/pixel_stream_feeder_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and an occupancy output.
// Data written into an empty FIFO becomes readable on the following cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 25,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             wr, rd;

   assign wr = wr_en & ~full_q;
   assign rd = rd_en & ~empty_q;

   always_comb begin
      wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      unique case ({wr, rd})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      full_d  = (level_d == DEPTH_L);
      empty_d = (level_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = full_q;
   assign empty   = empty_q;
   assign level   = level_q;

endmodule

// File: rtl/pixel_stream_feeder.sv
// Buffers source pixels and issues them one per handshake to the image processor,
// tracking x/y position. Define FEEDER_STATS_EN to add stall/overflow statistics.
module pixel_stream_feeder
   import pixel_stream_feeder_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
   parameter int unsigned FRAME_WIDTH  = DEF_FRAME_WIDTH,
   parameter int unsigned FRAME_HEIGHT = DEF_FRAME_HEIGHT
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [RGB_W-1:0]                src_rgb,
   input  logic                            src_sof,
   input  logic                            src_valid,
   output logic                            src_ready,
   input  logic                            matrix_valid,
   output logic [RGB_W-1:0]                proc_rgb,
   output logic                            proc_valid,
   input  logic                            proc_ready,
   output logic [$clog2(FRAME_WIDTH)-1:0]  pix_x,
   output logic [$clog2(FRAME_HEIGHT)-1:0] pix_y,
   output logic                            frame_done,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            busy
`ifdef FEEDER_STATS_EN
   ,
   output logic [31:0]                     stall_cycles,
   output logic                            overflow_seen
`endif
);

   localparam int unsigned XW = $clog2(FRAME_WIDTH);
   localparam int unsigned YW = $clog2(FRAME_HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

   feed_state_e        state_q, state_d;
   logic               proc_valid_q, proc_valid_d;
   logic [RGB_W-1:0]   proc_rgb_q, proc_rgb_d;
   logic [XW-1:0]      pix_x_q, pix_x_d;
   logic [YW-1:0]      pix_y_q, pix_y_d;
   logic               frame_done_q, frame_done_d;

   logic               fifo_full, fifo_empty, push, pop;
   logic [ENTRY_W-1:0] fifo_rd_data;
   feed_entry_t        head;

   assign src_ready = ~fifo_full;
   assign push      = src_valid & ~fifo_full;
   assign head      = feed_entry_t'(fifo_rd_data);

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (push),
      .wr_data ({src_sof, src_rgb}),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_comb begin
      state_d      = state_q;
      proc_valid_d = 1'b0;
      proc_rgb_d   = proc_rgb_q;
      pop          = 1'b0;
      unique case (state_q)
         FEED_IDLE: begin
            if (!fifo_empty && matrix_valid && proc_ready) begin
               pop          = 1'b1;
               proc_valid_d = 1'b1;
               proc_rgb_d   = head.rgb;
               state_d      = FEED_WAIT_ACK;
            end
         end
         // A processor that keeps input_ready high never acknowledges, so we stay here.
         FEED_WAIT_ACK: if (!proc_ready) state_d = FEED_WAIT_RDY;
         FEED_WAIT_RDY: if (proc_ready)  state_d = FEED_IDLE;
         default:       state_d = FEED_IDLE;
      endcase

      pix_x_d = pix_x_q;
      pix_y_d = pix_y_q;
      if (pop) begin
         if (head.sof) begin
            pix_x_d = '0;
            pix_y_d = '0;
         end else if (pix_x_q == X_LAST) begin
            pix_x_d = '0;
            pix_y_d = (pix_y_q == Y_LAST) ? '0 : pix_y_q + YW'(1);
         end else begin
            pix_x_d = pix_x_q + XW'(1);
         end
      end
      frame_done_d = pop && (pix_x_d == X_LAST) && (pix_y_d == Y_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FEED_IDLE;
         proc_valid_q <= 1'b0;
         proc_rgb_q   <= '0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         proc_valid_q <= proc_valid_d;
         proc_rgb_q   <= proc_rgb_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign proc_valid = proc_valid_q;
   assign proc_rgb   = proc_rgb_q;
   assign pix_x      = pix_x_q;
   assign pix_y      = pix_y_q;
   assign frame_done = frame_done_q;
   assign busy       = ~fifo_empty | (state_q != FEED_IDLE);

`ifdef FEEDER_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic        overflow_seen_q, overflow_seen_d;
   logic        stalled;

   assign stalled = ~fifo_empty & matrix_valid & ((state_q != FEED_IDLE) | ~proc_ready);

   always_comb begin
      stall_cycles_d  = (stalled && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
      overflow_seen_d = overflow_seen_q | (src_valid & fifo_full);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q  <= '0;
         overflow_seen_q <= 1'b0;
      end else begin
         stall_cycles_q  <= stall_cycles_d;
         overflow_seen_q <= overflow_seen_d;
      end
   end

   assign stall_cycles  = stall_cycles_q;
   assign overflow_seen = overflow_seen_q;
`endif

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Scoreboard bench for pixel_stream_feeder (4x2 frame, 4-entry FIFO) with a processor stub.
module tb_pixel_stream_feeder;

   localparam int unsigned FD = 4;
   localparam int unsigned FW = 4;
   localparam int unsigned FH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] src_rgb = '0;
   logic        src_sof = 1'b0;
   logic        src_valid = 1'b0;
   logic        src_ready;
   logic        matrix_valid = 1'b0;
   logic [23:0] proc_rgb;
   logic        proc_valid;
   logic        proc_ready = 1'b1;
   logic [1:0]  pix_x;
   logic [0:0]  pix_y;
   logic        frame_done;
   logic [2:0]  fifo_level;
   logic        busy;
`ifdef FEEDER_STATS_EN
   logic [31:0] stall_cycles;
   logic        overflow_seen;
`endif

   pixel_stream_feeder #(
      .FIFO_DEPTH   (FD),
      .FRAME_WIDTH  (FW),
      .FRAME_HEIGHT (FH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .src_rgb      (src_rgb),
      .src_sof      (src_sof),
      .src_valid    (src_valid),
      .src_ready    (src_ready),
      .matrix_valid (matrix_valid),
      .proc_rgb     (proc_rgb),
      .proc_valid   (proc_valid),
      .proc_ready   (proc_ready),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .frame_done   (frame_done),
      .fifo_level   (fifo_level),
      .busy         (busy)
`ifdef FEEDER_STATS_EN
      ,
      .stall_cycles (stall_cycles),
      .overflow_seen(overflow_seen)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] rgb;
      int          x;
      int          y;
      bit          done;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned issue_cnt = 0;
   int unsigned done_cnt = 0;
   // 0: handshaking processor, 1: ready stuck high, 2: ready stuck low
   int unsigned mode = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      unique case (mode)
         0:       proc_ready = ~proc_valid;
         1:       proc_ready = 1'b1;
         default: proc_ready = 1'b0;
      endcase
   end

   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n) begin
         if (proc_valid) begin
            issue_cnt++;
            if (frame_done) done_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_issue", 64'(proc_valid), 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("proc_rgb", 64'(proc_rgb), 64'(mon_e.rgb));
               chk("pix_x", 64'(pix_x), 64'(mon_e.x));
               chk("pix_y", 64'(pix_y), 64'(mon_e.y));
               chk("frame_done", 64'(frame_done), 64'(mon_e.done));
            end
         end else if (frame_done) begin
            chk("stray_frame_done", 64'(frame_done), 64'd0);
         end
      end
   end

   task automatic push_px(input logic [23:0] rgb, input logic sof, input int x, input int y,
                          input bit done);
      int unsigned n = 0;
      exp_t e;
      e.rgb = rgb; e.x = x; e.y = y; e.done = done;
      exp_q.push_back(e);
      src_rgb = rgb; src_sof = sof; src_valid = 1'b1;
      while (!src_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!src_ready) begin
         chk("push_timeout", 64'(src_ready), 64'd1);
         src_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      src_valid = 1'b0;
      src_sof   = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      int unsigned n;

      repeat (2) @(negedge clk);
      chk("rst_proc_valid", 64'(proc_valid), 64'd0);
      chk("rst_proc_rgb", 64'(proc_rgb), 64'd0);
      chk("rst_pix_xy", 64'({pix_x, pix_y}), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_fifo_level", 64'(fifo_level), 64'd0);
      chk("rst_src_ready", 64'(src_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
`ifdef FEEDER_STATS_EN
      chk("rst_stall", 64'(stall_cycles), 64'd0);
      chk("rst_overflow", 64'(overflow_seen), 64'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Held back until the matrix is valid, then in order.
      push_px(24'hFF0000, 1'b1, 0, 0, 1'b0);
      push_px(24'h00FF00, 1'b0, 1, 0, 1'b0);
      push_px(24'h0000FF, 1'b0, 2, 0, 1'b0);
      repeat (3) @(negedge clk);
      chk("t1_level", 64'(fifo_level), 64'd3);
      chk("t1_no_issue", 64'(issue_cnt), 64'd0);
      chk("t1_busy", 64'(busy), 64'd1);
      matrix_valid = 1'b1;
      wait_drain("t1_drain");
      chk("t1_issues", 64'(issue_cnt), 64'd3);
      chk("t1_hold_rgb", 64'(proc_rgb), 64'h0000FF);

      // Full 4x2 frame, y wrap, then an early sof truncating the next frame.
      base = done_cnt;
      push_px(24'h000001, 1'b1, 0, 0, 1'b0);
      push_px(24'h000002, 1'b0, 1, 0, 1'b0);
      push_px(24'h000003, 1'b0, 2, 0, 1'b0);
      push_px(24'h000004, 1'b0, 3, 0, 1'b0);
      push_px(24'h000005, 1'b0, 0, 1, 1'b0);
      push_px(24'h000006, 1'b0, 1, 1, 1'b0);
      push_px(24'h000007, 1'b0, 2, 1, 1'b0);
      push_px(24'h000008, 1'b0, 3, 1, 1'b1);
      push_px(24'h000009, 1'b0, 0, 0, 1'b0);
      push_px(24'h00000A, 1'b0, 1, 0, 1'b0);
      push_px(24'h00000B, 1'b1, 0, 0, 1'b0);
      push_px(24'h00000C, 1'b0, 1, 0, 1'b0);
      wait_drain("t2_drain");
      chk("t2_done_pulses", 64'(done_cnt - base), 64'd1);

      // Ready stuck high: one issue only, FSM parked awaiting acknowledge.
      mode = 1;
      repeat (2) @(negedge clk);
      base = issue_cnt;
      push_px(24'h123456, 1'b1, 0, 0, 1'b0);
      push_px(24'h654321, 1'b0, 1, 0, 1'b0);
      repeat (10) @(negedge clk);
      chk("t3_single_issue", 64'(issue_cnt - base), 64'd1);
      chk("t3_level", 64'(fifo_level), 64'd1);
      chk("t3_busy", 64'(busy), 64'd1);
      mode = 2;
      repeat (2) @(negedge clk);
      mode = 0;
      wait_drain("t3_drain");
      chk("t3_issues", 64'(issue_cnt - base), 64'd2);

      // matrix_valid drops after an issue: handshake finishes, next pixel waits.
      base = issue_cnt;
      push_px(24'hAA0000, 1'b1, 0, 0, 1'b0);
      push_px(24'h00BB00, 1'b0, 1, 0, 1'b0);
      n = 0;
      while (issue_cnt == base && n < 100) begin
         @(negedge clk);
         n++;
      end
      matrix_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("t6_paused_issues", 64'(issue_cnt - base), 64'd1);
      chk("t6_level", 64'(fifo_level), 64'd1);
      matrix_valid = 1'b1;
      wait_drain("t6_drain");
      chk("t6_issues", 64'(issue_cnt - base), 64'd2);

      // Fill the FIFO with the processor not ready; fifth pixel stays at the source.
      mode = 2;
      repeat (2) @(negedge clk);
      base = issue_cnt;
      push_px(24'h100001, 1'b1, 0, 0, 1'b0);
      push_px(24'h100002, 1'b0, 1, 0, 1'b0);
      push_px(24'h100003, 1'b0, 2, 0, 1'b0);
      push_px(24'h100004, 1'b0, 3, 0, 1'b0);
      chk("t4_src_ready_full", 64'(src_ready), 64'd0);
      chk("t4_level_full", 64'(fifo_level), 64'd4);
      fork
         push_px(24'h100005, 1'b0, 0, 1, 1'b0);
      join_none
      repeat (5) @(negedge clk);
      chk("t4_level_held", 64'(fifo_level), 64'd4);
      chk("t4_ready_held", 64'(src_ready), 64'd0);
      chk("t4_no_issue", 64'(issue_cnt - base), 64'd0);
`ifdef FEEDER_STATS_EN
      chk("t4_overflow_seen", 64'(overflow_seen), 64'd1);
      chk("t4_stall_nonzero", 64'(stall_cycles != 32'd0), 64'd1);
`endif
      mode = 0;
      wait_drain("t4_drain");
      chk("t4_issues", 64'(issue_cnt - base), 64'd5);

      // Reset while parked in WAIT_ACK with three pixels queued.
      mode = 1;
      repeat (2) @(negedge clk);
      base = issue_cnt;
      push_px(24'h200001, 1'b1, 0, 0, 1'b0);
      push_px(24'h200002, 1'b0, 1, 0, 1'b0);
      push_px(24'h200003, 1'b0, 2, 0, 1'b0);
      push_px(24'h200004, 1'b0, 3, 0, 1'b0);
      repeat (3) @(negedge clk);
      chk("t5_level_before", 64'(fifo_level), 64'd3);
      chk("t5_issue_before", 64'(issue_cnt - base), 64'd1);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("t5_proc_valid", 64'(proc_valid), 64'd0);
      chk("t5_level", 64'(fifo_level), 64'd0);
      chk("t5_src_ready", 64'(src_ready), 64'd1);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_pix_xy", 64'({pix_x, pix_y}), 64'd0);
`ifdef FEEDER_STATS_EN
      chk("t5_overflow_clr", 64'(overflow_seen), 64'd0);
`endif
      mode = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      base = issue_cnt;
      push_px(24'h300000, 1'b1, 0, 0, 1'b0);
      wait_drain("t5_drain");
      chk("t5_post_issue", 64'(issue_cnt - base), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
